vga_timing_ctrl: RTL and testbench
==================================

// Module: vga_timing_ctrl
// PURPOSE
//   Sequences the VGA pixel datapath of the farnold_vga1 design: generates the
//   horizontal/vertical raster position, sync pulses, blanking and line/frame
//   strobes. Pixel generators consume hpos/vpos/display_on; uo_out maps hsync/vsync.
//   Sits directly under the tt_um top, clocked by the 25.175 MHz pixel clock.
// PARAMETERS
//   H_ACTIVE 640  visible pixels per line
//   H_FRONT  16   horizontal front porch (pixels)
//   H_SYNC   96   horizontal sync width (pixels)
//   H_BACK   48   horizontal back porch (pixels)
//   V_ACTIVE 480  visible lines per frame
//   V_FRONT  10   vertical front porch (lines)
//   V_SYNC   2    vertical sync width (lines)
//   V_BACK   33   vertical back porch (lines)
//   SYNC_POL 0    asserted level of hsync/vsync (0 = active-low, 640x480 std)
// PORTS
//   clk        in   1   pixel clock; all state updates on rising edge
//   rst_n      in   1   synchronous active-low reset
//   run        in   1   1 = advance raster one pixel per clk; 0 = freeze
//   hpos       out  10  current column, 0..H_TOTAL-1 (H_TOTAL=sum of H_*, 800)
//   vpos       out  10  current line, 0..V_TOTAL-1 (V_TOTAL=sum of V_*, 525)
//   hsync      out  1   horizontal sync, SYNC_POL when asserted
//   vsync      out  1   vertical sync, SYNC_POL when asserted
//   display_on out  1   1 when hpos<H_ACTIVE and vpos<V_ACTIVE
//   line_start out  1   1-cycle pulse when hpos wraps to 0
//   frame_start out 1   1-cycle pulse when (hpos,vpos) wraps to (0,0)
//   frame_cnt  out  8   frames completed since reset, mod 256
// BEHAVIOUR
//   - Reset (rst_n=0 at clk edge): hpos=0, vpos=0, frame_cnt=0, hsync=vsync=!SYNC_POL,
//     display_on=0, line_start=0, frame_start=0. Reset wins over run.
//   - All outputs are registers, updated together: every output always describes the
//     position held in hpos/vpos (zero decode latency relative to counters). Sole
//     exception: display_on forced 0 while in reset; first run cycle after release
//     moves to (1,0) with display_on=1 (pixel (0,0) of first frame is blanked).
//   - Horizontal FSM states H_ACT -> H_FP -> H_SYN -> H_BP -> H_ACT; transitions when
//     hpos reaches 640, 656, 752, 0 (generic: cumulative parameter sums).
//     Vertical FSM V_ACT/V_FP/V_SYN/V_BP, same scheme on vpos (480, 490, 492, 0),
//     stepping only on horizontal wrap.
//   - run=1 per clk: hpos+=1; at hpos=H_TOTAL-1 hpos->0 and vpos+=1; at
//     vpos=V_TOTAL-1 with horizontal wrap, vpos->0 and frame_cnt+=1 (8-bit wrap 255->0).
//   - hsync asserted iff hpos in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC) = [656,752).
//     vsync asserted iff vpos in [490,492), independent of hpos.
//   - line_start=1 exactly in the cycle hpos becomes 0 via wrap; frame_start=1 exactly
//     in the cycle (hpos,vpos) becomes (0,0) via wrap (line_start also 1 then).
//     Neither pulses out of reset.
//   - run=0: hpos, vpos, frame_cnt, syncs, display_on hold; line_start/frame_start
//     forced 0 (no repeated strobes); resume continues from held position.
//   - Counters never exceed H_TOTAL-1 / V_TOTAL-1; no illegal FSM states reachable;
//     any unreachable encoding returns to H_ACT/V_ACT on next clk.
//   - Reset mid-line/mid-frame: next edge returns to reset state, no strobe emitted.
// TESTING
//   1. Reset 3 clks, release, run=1: hpos=1 vpos=0 after 1 clk; display_on=1; hsync=vsync=1.
//   2. Run 656 clks from (0,0): hsync=0 at hpos=656, back to 1 at hpos=752 (96 clks low).
//   3. Run one full line: hpos 799->0, vpos 0->1, line_start=1 one cycle, frame_start=0.
//   4. Run 800*525 clks: vsync low exactly lines 490-491 (1600 clks); frame_start
//      at (0,0), frame_cnt=1; display_on count per frame = 307200.
//   5. Drop run at hpos=799: outputs frozen 10 clks, no strobes; raise run -> wrap with
//      single line_start.
//   6. Assert rst_n=0 at (700,300) with hsync low: next clk all reset values; force 256
//      frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: pixel/line counters, H/V region FSMs, registered
// sync, blanking and line/frame strobes that always describe the held position.
module vga_timing_ctrl #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FRONT  = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BACK   = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FRONT  = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BACK   = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Region boundaries: the column/line at which each region begins.
  localparam logic [9:0] H_FP_START  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYN_START = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] H_BP_START  = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_FP_START  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYN_START = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] V_BP_START  = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {H_ACT, H_FP, H_SYN, H_BP} h_state_t;
  typedef enum logic [1:0] {V_ACT, V_FP, V_SYN, V_BP} v_state_t;

  h_state_t   h_state, h_state_next;
  v_state_t   v_state, v_state_next;
  logic [9:0] hpos_next, vpos_next;
  logic       h_wrap, f_wrap;

  // Next raster position; outputs are decoded from it so they land in the same
  // register stage as the counters themselves.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    hpos_next = hpos;
    vpos_next = vpos;
    h_wrap    = 1'b0;
    f_wrap    = 1'b0;
    if (run) begin
      if (hpos >= H_LAST) begin
        hpos_next = '0;
        h_wrap    = 1'b1;
        if (vpos >= V_LAST) begin
          vpos_next = '0;
          f_wrap    = 1'b1;
        end else begin
          vpos_next = vpos + 10'd1;
        end
      end else begin
        hpos_next = hpos + 10'd1;
      end
    end
  end

  always_comb begin
    h_state_next = h_state;
    unique case (h_state)
      H_ACT:   if (hpos_next == H_FP_START)  h_state_next = H_FP;
      H_FP:    if (hpos_next == H_SYN_START) h_state_next = H_SYN;
      H_SYN:   if (hpos_next == H_BP_START)  h_state_next = H_BP;
      H_BP:    if (hpos_next == '0)          h_state_next = H_ACT;
      default: h_state_next = H_ACT;
    endcase
  end

  // vpos_next only moves on a horizontal wrap, so this FSM steps once per line.
  always_comb begin
    v_state_next = v_state;
    unique case (v_state)
      V_ACT:   if (vpos_next == V_FP_START)  v_state_next = V_FP;
      V_FP:    if (vpos_next == V_SYN_START) v_state_next = V_SYN;
      V_SYN:   if (vpos_next == V_BP_START)  v_state_next = V_BP;
      V_BP:    if (vpos_next == '0)          v_state_next = V_ACT;
      default: v_state_next = V_ACT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      h_state     <= H_ACT;
      v_state     <= V_ACT;
      hpos        <= '0;
      vpos        <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      display_on  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      h_state     <= h_state_next;
      v_state     <= v_state_next;
      hpos        <= hpos_next;
      vpos        <= vpos_next;
      hsync       <= (h_state_next == H_SYN) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (v_state_next == V_SYN) ? SYNC_POL : ~SYNC_POL;
      line_start  <= h_wrap;
      frame_start <= f_wrap;
      frame_cnt   <= frame_cnt + {7'd0, f_wrap};
      // Held while frozen so pixel (0,0) stays blanked until the first run cycle.
      if (run)
        display_on <= (h_state_next == H_ACT) && (v_state_next == V_ACT);
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a 640x480 instance for line-level behaviour and a
// tiny-raster instance (inverted sync polarity) for whole-frame and wrap behaviour.
module tb_vga_timing_ctrl;

  typedef struct packed {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
    bit pol;
  } cfg_t;

  typedef struct packed {
    int h; int v; int f;
    bit blank; bit ls; bit fs;
  } mstate_t;

  localparam cfg_t CFG_A = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, pol:1'b0};
  localparam cfg_t CFG_B = '{ha:8,   hf:2,  hs:3,  hb:2,  va:4,   vf:1,  vs:2, vb:2,  pol:1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a = 1'b0, run_a = 1'b0;
  logic [9:0] hpos_a, vpos_a;
  logic       hsync_a, vsync_a, disp_a, ls_a, fs_a;
  logic [7:0] fcnt_a;

  logic       rst_n_b = 1'b0, run_b = 1'b0;
  logic [9:0] hpos_b, vpos_b;
  logic       hsync_b, vsync_b, disp_b, ls_b, fs_b;
  logic [7:0] fcnt_b;

  vga_timing_ctrl dut_a (
    .clk(clk), .rst_n(rst_n_a), .run(run_a),
    .hpos(hpos_a), .vpos(vpos_a), .hsync(hsync_a), .vsync(vsync_a),
    .display_on(disp_a), .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fcnt_a)
  );

  vga_timing_ctrl #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .run(run_b),
    .hpos(hpos_b), .vpos(vpos_b), .hsync(hsync_b), .vsync(vsync_b),
    .display_on(disp_b), .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fcnt_b)
  );

  int tests  = 0;
  int failed = 0;
  mstate_t ms_a, ms_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      if (failed <= 25) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: raster position as plain integer arithmetic.
  function automatic mstate_t mstep(mstate_t s, cfg_t c, bit rst, bit run);
    int htot = c.ha + c.hf + c.hs + c.hb;
    int vtot = c.va + c.vf + c.vs + c.vb;
    if (!rst) begin
      s.h = 0; s.v = 0; s.f = 0; s.blank = 1'b1; s.ls = 1'b0; s.fs = 1'b0;
    end else begin
      s.ls = 1'b0; s.fs = 1'b0;
      if (run) begin
        s.blank = 1'b0;
        s.h++;
        if (s.h == htot) begin
          s.h = 0; s.ls = 1'b1; s.v++;
          if (s.v == vtot) begin
            s.v = 0; s.fs = 1'b1; s.f = (s.f + 1) % 256;
          end
        end
      end
    end
    return s;
  endfunction

  function automatic logic exp_hsync(mstate_t s, cfg_t c);
    return (s.h >= c.ha + c.hf && s.h < c.ha + c.hf + c.hs) ? c.pol : ~c.pol;
  endfunction

  function automatic logic exp_vsync(mstate_t s, cfg_t c);
    return (s.v >= c.va + c.vf && s.v < c.va + c.vf + c.vs) ? c.pol : ~c.pol;
  endfunction

  function automatic logic exp_disp(mstate_t s, cfg_t c);
    return !s.blank && s.h < c.ha && s.v < c.va;
  endfunction

  task automatic tick_a(input bit rst, input bit run);
    rst_n_a = rst; run_a = run;
    @(posedge clk); #1;
    ms_a = mstep(ms_a, CFG_A, rst, run);
    check("a_hpos",  32'(hpos_a), 32'(ms_a.h));
    check("a_vpos",  32'(vpos_a), 32'(ms_a.v));
    check("a_hsync", 32'(hsync_a), 32'(exp_hsync(ms_a, CFG_A)));
    check("a_vsync", 32'(vsync_a), 32'(exp_vsync(ms_a, CFG_A)));
    check("a_disp",  32'(disp_a), 32'(exp_disp(ms_a, CFG_A)));
    check("a_line_start",  32'(ls_a), 32'(ms_a.ls));
    check("a_frame_start", 32'(fs_a), 32'(ms_a.fs));
    check("a_frame_cnt",   32'(fcnt_a), 32'(ms_a.f));
  endtask

  task automatic tick_b(input bit rst, input bit run);
    rst_n_b = rst; run_b = run;
    @(posedge clk); #1;
    ms_b = mstep(ms_b, CFG_B, rst, run);
    check("b_hpos",  32'(hpos_b), 32'(ms_b.h));
    check("b_vpos",  32'(vpos_b), 32'(ms_b.v));
    check("b_hsync", 32'(hsync_b), 32'(exp_hsync(ms_b, CFG_B)));
    check("b_vsync", 32'(vsync_b), 32'(exp_vsync(ms_b, CFG_B)));
    check("b_disp",  32'(disp_b), 32'(exp_disp(ms_b, CFG_B)));
    check("b_line_start",  32'(ls_b), 32'(ms_b.ls));
    check("b_frame_start", 32'(fs_b), 32'(ms_b.fs));
    check("b_frame_cnt",   32'(fcnt_b), 32'(ms_b.f));
  endtask

  initial begin
    int hs_low, ls_seen, vs_cnt, de_cnt, frames;
    int htot_b, vtot_b;
    ms_a = '0; ms_b = '0;
    htot_b = CFG_B.ha + CFG_B.hf + CFG_B.hs + CFG_B.hb;
    vtot_b = CFG_B.va + CFG_B.vf + CFG_B.vs + CFG_B.vb;

    // Reset held for 3 clocks with run high: reset must win.
    for (int i = 0; i < 3; i++) tick_a(1'b0, 1'b1);
    tick_a(1'b1, 1'b1);
    check("t1_hpos", 32'(hpos_a), 32'd1);
    check("t1_disp", 32'(disp_a), 32'd1);

    // Rest of line 0: hsync low for exactly H_SYNC clocks.
    hs_low = 0;
    for (int i = 0; i < 2000 && ms_a.h != 799; i++) begin
      tick_a(1'b1, 1'b1);
      if (hsync_a == 1'b0) hs_low++;
    end
    check("t2_hsync_low_clks", 32'(hs_low), 32'(CFG_A.hs));
    tick_a(1'b1, 1'b1);
    check("t3_vpos_after_wrap", 32'(vpos_a), 32'd1);
    check("t3_line_start", 32'(ls_a), 32'd1);

    // Freeze at the last column, then resume: exactly one line_start.
    for (int i = 0; i < 2000 && ms_a.h != 799; i++) tick_a(1'b1, 1'b1);
    ls_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick_a(1'b1, 1'b0);
      ls_seen += int'(ls_a) + int'(fs_a);
    end
    check("t5_strobes_frozen", 32'(ls_seen), 32'd0);
    check("t5_hpos_frozen", 32'(hpos_a), 32'd799);
    tick_a(1'b1, 1'b1);
    tick_a(1'b1, 1'b1);
    check("t5_hpos_resumed", 32'(hpos_a), 32'd1);

    // Randomised run gating with occasional resets.
    for (int i = 0; i < 4000; i++)
      tick_a(($urandom_range(0, 499) != 0), ($urandom_range(0, 3) != 0));

    // Reset mid-line while hsync is asserted.
    for (int i = 0; i < 2000 && ms_a.h != 700; i++) tick_a(1'b1, 1'b1);
    check("t6_hsync_low_at_700", 32'(hsync_a), 32'd0);
    tick_a(1'b0, 1'b1);
    check("t6_hpos_reset", 32'(hpos_a), 32'd0);
    check("t6_hsync_reset", 32'(hsync_a), 32'd1);
    check("t6_disp_reset", 32'(disp_a), 32'd0);
    rst_n_a = 1'b0; run_a = 1'b0;

    // Small raster: one warm-up frame, then measure a full frame from (0,0).
    tick_b(1'b0, 1'b0);
    tick_b(1'b0, 1'b1);
    for (int i = 0; i < htot_b * vtot_b; i++) tick_b(1'b1, 1'b1);
    check("t4_frame_start", 32'(fs_b), 32'd1);
    check("t4_frame_cnt_1", 32'(fcnt_b), 32'd1);
    vs_cnt = 0; de_cnt = 0;
    for (int i = 0; i < htot_b * vtot_b; i++) begin
      if (vsync_b == CFG_B.pol) vs_cnt++;
      if (disp_b) de_cnt++;
      tick_b(1'b1, 1'b1);
    end
    check("t4_vsync_clks", 32'(vs_cnt), 32'(CFG_B.vs * htot_b));
    check("t4_display_clks", 32'(de_cnt), 32'(CFG_B.ha * CFG_B.va));
    check("t4_frame_cnt_2", 32'(fcnt_b), 32'd2);

    // Randomly gated run through 256 frames total: frame_cnt wraps to 0.
    frames = 2;
    for (int i = 0; i < 60000 && frames < 256; i++) begin
      tick_b(1'b1, ($urandom_range(0, 9) != 0));
      if (fs_b) frames++;
    end
    check("t6_frames_done", 32'(frames), 32'd256);
    check("t6_frame_cnt_wrap", 32'(fcnt_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
